// File: rtl/pe_ms.sv
// Multi-mode systolic processing element: weight-stationary or output-stationary dataflow,
// double-buffered weights, signed/unsigned MAC with optional saturation and a sticky overflow flag.
module pe_ms #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode,
  input  logic              weight_load,
  input  logic              weight_swap,
  input  logic              drain,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] weight_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] weight_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  // Adds two ACC_W operands one bit wider; returns {overflow, clamped-or-wrapped result}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
    logic [ACC_W:0]   s;
    logic             of;
    logic [ACC_W-1:0] r;
    if (SIGNED != 0) begin
      s  = {x[ACC_W-1], x} + {y[ACC_W-1], y};
      of = s[ACC_W] ^ s[ACC_W-1];
      if (of && (SAT != 0)) begin
        r = s[ACC_W] ? SMIN : SMAX;
      end else begin
        r = s[ACC_W-1:0];
      end
    end else begin
      s  = {1'b0, x} + {1'b0, y};
      of = s[ACC_W];
      if (of && (SAT != 0)) begin
        r = UMAX;
      end else begin
        r = s[ACC_W-1:0];
      end
    end
    return {of, r};
  endfunction

  logic [DATA_W-1:0]   shadow_r;
  logic [DATA_W-1:0]   active_r;
  logic [ACC_W-1:0]    acc_r;
  logic [DATA_W-1:0]   w_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    p_ext_s;
  logic [ACC_W-1:0]    ws_sum_s;
  logic [ACC_W-1:0]    os_sum_s;
  logic                ws_ovf_s;
  logic                os_ovf_s;
  logic [ACC_W-1:0]    psum_nxt_s;
  logic [ACC_W-1:0]    acc_upd_s;
  logic [ACC_W-1:0]    acc_nxt_s;
  logic                ovf_upd_s;
  logic                ovf_nxt_s;
  logic [DATA_W-1:0]   wout_nxt_s;

  // Operand select, product and the two candidate sums (psum chain in WS, accumulator in OS).
  always_comb begin
    w_s = mode ? weight_in : active_r;
    if (SIGNED != 0) begin
      prod_s  = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) * $signed({{DATA_W{w_s[DATA_W-1]}}, w_s});
      p_ext_s = ACC_W'($signed(prod_s));
    end else begin
      prod_s  = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w_s};
      p_ext_s = ACC_W'(prod_s);
    end
    {ws_ovf_s, ws_sum_s} = sat_add(psum_in, p_ext_s);
    {os_ovf_s, os_sum_s} = sat_add(acc_r, p_ext_s);
  end

  // Next-state for psum_out, accumulator, overflow flag and weight chain.
  always_comb begin
    psum_nxt_s = psum_in;
    acc_upd_s  = acc_r;
    ovf_upd_s  = ovf;
    wout_nxt_s = weight_out;
    if (!mode) begin
      if (a_valid_in) begin
        psum_nxt_s = ws_sum_s;
        ovf_upd_s  = ovf | ws_ovf_s;
      end else begin
        psum_nxt_s = psum_in;
      end
      if (weight_load) begin
        wout_nxt_s = weight_in;
      end else begin
        wout_nxt_s = weight_out;
      end
    end else begin
      wout_nxt_s = weight_in;
      if (drain) begin
        // Drain emits the pre-update value and restarts the sum with this cycle's product.
        psum_nxt_s = acc_r;
        acc_upd_s  = a_valid_in ? p_ext_s : {ACC_W{1'b0}};
      end else if (a_valid_in) begin
        acc_upd_s = os_sum_s;
        ovf_upd_s = ovf | os_ovf_s;
      end else begin
        acc_upd_s = acc_r;
      end
    end
    acc_nxt_s = clear ? {ACC_W{1'b0}} : acc_upd_s;
    ovf_nxt_s = clear ? 1'b0 : ovf_upd_s;
  end

  // Weight double buffer; a simultaneous load+swap moves the old shadow into active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r <= {DATA_W{1'b0}};
      active_r <= {DATA_W{1'b0}};
    end else begin
      if (weight_load) shadow_r <= weight_in;
      if (weight_swap) active_r <= shadow_r;
    end
  end

  // Registered outputs and accumulator state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r       <= {ACC_W{1'b0}};
      ovf         <= 1'b0;
      psum_out    <= {ACC_W{1'b0}};
      weight_out  <= {DATA_W{1'b0}};
      a_out       <= {DATA_W{1'b0}};
      a_valid_out <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      ovf         <= ovf_nxt_s;
      psum_out    <= psum_nxt_s;
      weight_out  <= wout_nxt_s;
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
    end
  end

endmodule

// File: tb/tb_pe_ms.sv
// Self-checking bench for pe_ms: four parameterisations share one stimulus stream;
// expectations are queued when stimulus is driven and compared after the next edge.
module tb_pe_ms;

  typedef struct {
    logic        clr, md, wl, ws, dr, av;
    logic [7:0]  a, w;
    logic [23:0] ps;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [23:0] exp_psum;
    logic [7:0]  exp_wout;
  } row_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  localparam int P0 = 0, P1 = 1, P2 = 2, P3 = 3;
  localparam int O0 = 4, O1 = 5, O2 = 6, O3 = 7;
  localparam int AO = 8, AV = 9, WO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, mode, weight_load, weight_swap, drain, a_valid_in;
  logic [7:0]  a_in, weight_in;
  logic [23:0] psum_in;

  logic [7:0]  a_out0, a_out1, a_out2, a_out3;
  logic        av_out0, av_out1, av_out2, av_out3;
  logic [7:0]  w_out0, w_out1, w_out2, w_out3;
  logic [23:0] psum0, psum3;
  logic [15:0] psum1, psum2;
  logic        ovf0, ovf1, ovf2, ovf3;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  row_t tbl[9];

  always #5 clk = ~clk;

  pe_ms #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SAT(1)) u_def (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .weight_load(weight_load),
    .weight_swap(weight_swap), .drain(drain), .a_in(a_in), .a_valid_in(a_valid_in),
    .weight_in(weight_in), .psum_in(psum_in), .a_out(a_out0), .a_valid_out(av_out0),
    .weight_out(w_out0), .psum_out(psum0), .ovf(ovf0));

  pe_ms #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SAT(1)) u_s16sat (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .weight_load(weight_load),
    .weight_swap(weight_swap), .drain(drain), .a_in(a_in), .a_valid_in(a_valid_in),
    .weight_in(weight_in), .psum_in(psum_in[15:0]), .a_out(a_out1), .a_valid_out(av_out1),
    .weight_out(w_out1), .psum_out(psum1), .ovf(ovf1));

  pe_ms #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SAT(0)) u_s16wrap (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .weight_load(weight_load),
    .weight_swap(weight_swap), .drain(drain), .a_in(a_in), .a_valid_in(a_valid_in),
    .weight_in(weight_in), .psum_in(psum_in[15:0]), .a_out(a_out2), .a_valid_out(av_out2),
    .weight_out(w_out2), .psum_out(psum2), .ovf(ovf2));

  pe_ms #(.DATA_W(8), .ACC_W(24), .SIGNED(0), .SAT(1)) u_uns (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode), .weight_load(weight_load),
    .weight_swap(weight_swap), .drain(drain), .a_in(a_in), .a_valid_in(a_valid_in),
    .weight_in(weight_in), .psum_in(psum_in), .a_out(a_out3), .a_valid_out(av_out3),
    .weight_out(w_out3), .psum_out(psum3), .ovf(ovf3));

  function automatic vec_t mkv(logic clr, logic md, logic wl, logic ws, logic dr, logic av,
                               logic [7:0] a, logic [7:0] w, logic [23:0] ps);
    vec_t v;
    v.clr = clr; v.md = md; v.wl = wl; v.ws = ws; v.dr = dr; v.av = av;
    v.a = a; v.w = w; v.ps = ps;
    return v;
  endfunction

  function automatic logic [31:0] get_val(int sel);
    case (sel)
      P0:      return {8'h00, psum0};
      P1:      return {16'h0000, psum1};
      P2:      return {16'h0000, psum2};
      P3:      return {8'h00, psum3};
      O0:      return {31'd0, ovf0};
      O1:      return {31'd0, ovf1};
      O2:      return {31'd0, ovf2};
      O3:      return {31'd0, ovf3};
      AO:      return {24'd0, a_out0};
      AV:      return {31'd0, av_out0};
      WO:      return {24'd0, w_out0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  task automatic expect_val(string name, int sel, logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drive(vec_t v);
    clear = v.clr; mode = v.md; weight_load = v.wl; weight_swap = v.ws; drain = v.dr;
    a_valid_in = v.av; a_in = v.a; weight_in = v.w; psum_in = v.ps;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, get_val(e.sel), e.val);
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    drive(v);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_psum", get_val(P0), 32'd0);
    check("reset_ovf", get_val(O0), 32'd0);
    check("reset_aout", get_val(AO), 32'd0);
    check("reset_wout", get_val(WO), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // WS basic and double-buffer table
    tbl[0] = '{mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5,  24'd0),   24'd0,   8'd5};
    tbl[1] = '{mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd77, 24'd0),   24'd0,   8'd5};
    tbl[2] = '{mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0,  24'd0),   24'd5,   8'd5};
    tbl[3] = '{mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0,  24'd0),   24'd10,  8'd5};
    tbl[4] = '{mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0,  24'd100), 24'd115, 8'd5};
    tbl[5] = '{mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,  24'd7),   24'd7,   8'd5};
    tbl[6] = '{mkv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd9,  24'd0),   24'd10,  8'd9};
    tbl[7] = '{mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0,  24'd1),   24'd11,  8'd9};
    tbl[8] = '{mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0,  24'd3),   24'd21,  8'd9};
    for (int i = 0; i < 9; i++) begin
      expect_val($sformatf("ws_psum[%0d]", i), P0, {8'h00, tbl[i].exp_psum});
      expect_val($sformatf("ws_wout[%0d]", i), WO, {24'd0, tbl[i].exp_wout});
      expect_val($sformatf("ws_aout[%0d]", i), AO, {24'd0, tbl[i].v.a});
      expect_val($sformatf("ws_avout[%0d]", i), AV, {31'd0, tbl[i].v.av});
      step(tbl[i].v);
    end

    // Signed overflow: saturating (16-bit) vs wrapping (16-bit)
    step(mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 24'd0));
    step(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0));
    expect_val("sat_pos_psum", P1, 32'h0000_7FFF);
    expect_val("sat_pos_ovf",  O1, 32'd1);
    expect_val("wrap_pos_psum", P2, 32'h0000_8000);
    expect_val("wrap_pos_ovf",  O2, 32'd1);
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 24'h007FFF));
    expect_val("sat_sticky_ovf", O1, 32'd1);
    expect_val("sat_idle_psum",  P1, 32'd0);
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0));
    expect_val("sat_neg_psum",  P1, 32'h0000_8000);
    expect_val("wrap_neg_psum", P2, 32'h0000_7FFF);
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd0, 24'h008000));
    expect_val("clear_ovf_sat",  O1, 32'd0);
    expect_val("clear_ovf_wrap", O2, 32'd0);
    step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0));

    // OS accumulate / drain on the default instance
    expect_val("os_chain0", P0, 32'd11);
    expect_val("os_wout0",  WO, 32'd3);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 24'd11));
    expect_val("os_chain1", P0, 32'd12);
    expect_val("os_wout1",  WO, 32'd5);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd5, 24'd12));
    expect_val("os_chain2", P0, 32'd13);
    expect_val("os_wout2",  WO, 32'd1);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 24'd13));
    expect_val("os_drain27", P0, 32'd27);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 24'd0));
    expect_val("os_chain44", P0, 32'd44);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd44));
    expect_val("os_drain9", P0, 32'd9);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 24'd0));
    expect_val("os_drain_zero", P0, 32'd0);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 24'd0));
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2, 24'd0));
    expect_val("os_clear_drain", P0, 32'd4);
    step(mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 8'd5, 24'd0));
    expect_val("os_after_clear", P0, 32'd0);
    step(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 24'd0));

    // Unsigned vs signed interpretation of 0xFF x 0xFF
    step(mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 24'd0));
    step(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0));
    expect_val("uns_prod", P3, 32'd65025);
    expect_val("sgn_prod", P0, 32'd1);
    expect_val("sgn16_prod", P1, 32'd1);
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd0, 24'd0));
    expect_val("uns_sat_psum", P3, 32'h00FF_FFFF);
    expect_val("uns_sat_ovf",  O3, 32'd1);
    expect_val("sgn_noovf_psum", P0, 32'd0);
    expect_val("sgn_noovf_ovf",  O0, 32'd0);
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd0, 24'hFFFFFF));

    // Asynchronous reset between edges, then release mid-stream
    step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd0, 24'h000123));
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_psum", get_val(P0), 32'd0);
    check("async_rst_aout", get_val(AO), 32'd0);
    check("async_rst_avout", get_val(AV), 32'd0);
    check("async_rst_wout", get_val(WO), 32'd0);
    check("async_rst_ovf3", get_val(O3), 32'd0);
    check("async_rst_psum3", get_val(P3), 32'd0);
    #1;
    rst = 1'b1;
    expect_val("post_rst_psum", P0, 32'h0000_0123);
    expect_val("post_rst_aout", AO, 32'd7);
    expect_val("post_rst_avout", AV, 32'd1);
    expect_val("post_rst_wout", WO, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_ms.md
# pe_ms

Parametrised multi-mode processing element for the systolic array, successor to the fixed 8-bit weight-stationary PE. It adds configurable operand and accumulator widths, signed or unsigned arithmetic, and optional saturation with a sticky overflow flag. A double-buffered weight register lets the next tile's weights load while the current tile computes. A run-time mode select chooses weight-stationary (WS) or output-stationary (OS) dataflow; the PE tiles into rows and columns exactly like its predecessor.

## Interface
- DATA_W, 8, activation/weight width
- ACC_W, 24, partial-sum/accumulator width; must be >= 2*DATA_W
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
- SAT, 1, 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of accumulator and ovf
- mode  in  1  0 = WS, 1 = OS; sampled every cycle
- weight_load  in  1  capture weight_in into shadow weight register
- weight_swap  in  1  copy shadow weight into active weight register
- drain  in  1  OS only: emit accumulator on psum_out
- a_in  in  DATA_W  activation from west
- a_valid_in  in  1  a_in is valid
- weight_in  in  DATA_W  weight from north (WS load chain / OS stream)
- psum_in  in  ACC_W  partial sum from north
- a_out  out  DATA_W  registered a_in, to east
- a_valid_out  out  1  registered a_valid_in
- weight_out  out  DATA_W  registered weight chain, to south
- psum_out  out  ACC_W  registered partial sum, to south
- ovf  out  1  sticky overflow/saturation flag

## Operation
- Product p = a_in * w (DATA_W x DATA_W -> 2*DATA_W), signed or unsigned per SIGNED, then sign- or zero-extended to ACC_W.
- Sum is computed at ACC_W+1 bits. On overflow: SAT=1 clamps to max/min representable value (unsigned: 2^ACC_W-1); SAT=0 wraps. Either way ovf is set, and it stays set until clear or reset.
- WS mode (mode=0): w = active weight.
  - a_valid_in=1: psum_out <= psum_in + p.
  - a_valid_in=0: psum_out <= psum_in, with no ovf update.
  - Internal accumulator is untouched.
- OS mode (mode=1): w = weight_in (streamed operand).
  - a_valid_in=1: acc <= acc + p.
  - drain=0: psum_out <= psum_in (shift-out chain).
  - drain=1: psum_out <= acc (value before this cycle's update), and acc <= p if a_valid_in, else 0.
- Weight buffering:
  - weight_load: shadow <= weight_in.
  - weight_swap: active <= shadow.
  - Both asserted in the same cycle: active gets the old shadow and shadow gets weight_in.
- weight_out:
  - WS: weight_out <= weight_in when weight_load=1, else holds. This forms the column load chain.
  - OS: weight_out <= weight_in every cycle.
- a_out <= a_in and a_valid_out <= a_valid_in every cycle, in both modes.
- clear: acc <= 0 and ovf <= 0. It overrides accumulation and the drain reload of acc. psum_out still takes its normal value, so clear+drain still emits the old acc. Shadow and active weights are unaffected.
- A mode change takes effect on the next edge. acc is retained across mode changes; software clears it before an OS tile.

## Timing
- Reset (rst=0, asynchronous): all outputs, acc, shadow and active weights are 0 immediately, independent of clk.
- Every output is registered, giving 1-cycle latency from any input to its effect.
- A swap asserted at edge N is used by the product at edge N+1.
- No combinational path from inputs to outputs.
- Reset deassertion mid-stream: the first edge with rst=1 processes inputs normally, starting from the zero state.

## Test plan
- Reset: drive rst=0 between edges, with all registers preloaded nonzero -> all outputs 0 immediately, before the next edge.
- WS basic (defaults): load 5, swap; then stream a = 1, 2, 3 with psum_in = 0, 0, 100 and valid -> psum_out = 5, 10, 115 one cycle later. A cycle with a_valid_in=0 and psum_in=7 -> psum_out=7.
- Double buffer: active=5; in one cycle assert load(9)+swap -> active=old shadow, shadow=9. Next swap, then a=2 -> psum_out = psum_in + 18.
- Signed/saturate (ACC_W=16, SAT=1, SIGNED=1): psum_in=32767, a=1, w=1 -> psum_out=32767 and ovf=1. Then clear -> ovf=0. The same case with SAT=0 -> psum_out=-32768 and ovf=1.
- OS accumulate/drain: mode=1, valid pairs (2,3), (4,5), (1,1) -> acc=27. Assert drain together with valid (3,3) -> psum_out=27, acc=9. Next cycle with drain=0 and psum_in=44 -> psum_out=44.
- Unsigned (SIGNED=0): a=255, w=255, psum_in=0 -> psum_out=65025. With SIGNED=1 the same bits (-1 x -1) -> psum_out=1.
